// File: rtl/timer_apb_regif.sv
// APB responder for the 8-bit timer: TDR/TCR/TSR register file, wait-state
// sequencing, W1C status flags and the control fields driven to the counter core.
module timer_apb_regif #(
    parameter int WAIT_STATES = 1
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       ovf_set,
    input  logic       udf_set,
    output logic [7:0] tdr_q,
    output logic       load_o,
    output logic       updw_o,
    output logic       en_o,
    output logic [1:0] cks_o,
    output logic       tdr_load_pulse
);

    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;
    localparam logic [7:0] TCR_MASK = 8'hB3;
    localparam logic [7:0] TSR_MASK = 8'h03;
    localparam logic [1:0] WAIT_CNT = WAIT_STATES[1:0];

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] wait_cnt_q;

    logic [7:0] addr_p0;
    logic       wr_p0;
    logic [7:0] wdata_p0;

    logic [7:0] tdr_r;
    logic [7:0] tcr_r;
    logic [7:0] tsr_r;

    logic       in_xfer;
    logic       wait_done;
    logic       xfer_done;
    logic       addr_ok;
    logic       wr_commit;
    logic [7:0] tsr_clr;

    function automatic logic [7:0] read_mux(input logic [7:0] sel_addr,
                                            input logic [7:0] tdr_v,
                                            input logic [7:0] tcr_v,
                                            input logic [7:0] tsr_v);
        case (sel_addr)
            ADDR_TDR: return tdr_v;
            ADDR_TCR: return tcr_v;
            ADDR_TSR: return tsr_v;
            default:  return 8'h00;
        endcase
    endfunction

    // A set pulse always beats a simultaneous W1C of the same bit.
    function automatic logic [7:0] tsr_update(input logic [7:0] cur,
                                              input logic [7:0] clr,
                                              input logic       ovf,
                                              input logic       udf);
        return ((cur & ~clr) | {6'b0, udf, ovf}) & TSR_MASK;
    endfunction

    assign in_xfer   = (state_q != IDLE);
    assign wait_done = (wait_cnt_q == WAIT_CNT);
    assign xfer_done = in_xfer && psel && penable && wait_done && !preset;
    assign addr_ok   = (addr_p0 <= ADDR_TSR);
    assign wr_commit = xfer_done && wr_p0;
    assign tsr_clr   = (wr_commit && addr_p0 == ADDR_TSR) ? wdata_p0 : 8'h00;

    // ---- state register ----
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE)
                wait_cnt_q <= 2'd0;
            else if (penable && !wait_done)
                wait_cnt_q <= wait_cnt_q + 2'd1;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (psel && !penable) state_d = SETUP;
            SETUP,
            ACCESS: state_d = (!psel || xfer_done) ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // ---- output logic ----
    always_comb begin
        pready  = xfer_done;
        pslverr = xfer_done && !addr_ok;
        prdata  = 8'h00;
        if (xfer_done && !wr_p0)
            prdata = read_mux(addr_p0, tdr_r, tcr_r, tsr_r);
    end

    // ---- setup-phase capture (bus holds these stable through the access) ----
    always_ff @(posedge pclk) begin
        if (state_q == IDLE && psel && !penable) begin
            addr_p0  <= paddr;
            wr_p0    <= pwrite;
            wdata_p0 <= pwdata;
        end
    end

    // ---- register file, committed on the edge that ends the pready cycle ----
    always_ff @(posedge pclk) begin
        if (preset) begin
            tdr_r          <= 8'h00;
            tcr_r          <= 8'h00;
            tsr_r          <= 8'h00;
            tdr_load_pulse <= 1'b0;
        end else begin
            if (wr_commit && addr_p0 == ADDR_TDR)
                tdr_r <= wdata_p0;
            if (wr_commit && addr_p0 == ADDR_TCR)
                tcr_r <= wdata_p0 & TCR_MASK;
            tsr_r          <= tsr_update(tsr_r, tsr_clr, ovf_set, udf_set);
            tdr_load_pulse <= wr_commit && (addr_p0 == ADDR_TCR) && wdata_p0[7];
        end
    end

    assign tdr_q  = tdr_r;
    assign load_o = tcr_r[7];
    assign updw_o = tcr_r[5];
    assign en_o   = tcr_r[4];
    assign cks_o  = tcr_r[1:0];

endmodule

// File: tb/tb_timer_apb_regif.sv
// Directed bench for timer_apb_regif with two wait states: register map,
// masks, W1C/set priority, unmapped access errors and reset mid-transfer.
module tb_timer_apb_regif;

    localparam int WS = 2;

    logic       pclk;
    logic       preset;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       ovf_set;
    logic       udf_set;
    logic [7:0] tdr_q;
    logic       load_o;
    logic       updw_o;
    logic       en_o;
    logic [1:0] cks_o;
    logic       tdr_load_pulse;

    int nvec = 0;
    int nerr = 0;

    timer_apb_regif #(.WAIT_STATES(WS)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .ovf_set(ovf_set), .udf_set(udf_set),
        .tdr_q(tdr_q), .load_o(load_o), .updw_o(updw_o), .en_o(en_o),
        .cks_o(cks_o), .tdr_load_pulse(tdr_load_pulse)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One APB transfer; pulse = {udf_set, ovf_set} driven during the pready cycle.
    task automatic apb(input string tag, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [1:0] pulse,
                       output logic [7:0] rd, output logic err);
        int   lat;
        logic got;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1; got = 1'b0; lat = 99; rd = 8'h00; err = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            #1;
            if (pready) begin
                got = 1'b1; lat = i; rd = prdata; err = pslverr;
                {udf_set, ovf_set} = pulse;
            end
            @(posedge pclk); #1;
        end
        udf_set = 1'b0; ovf_set = 1'b0; psel = 1'b0; penable = 1'b0;
        chk({tag, ".lat"}, lat, WS + 1);
        chk({tag, ".pready_1cyc"}, {31'b0, pready}, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [1:0] pulse,
                          input logic [7:0] exp, input logic exp_err);
        logic [7:0] rd;
        logic       err;
        apb(tag, 1'b0, a, 8'h00, pulse, rd, err);
        chk({tag, ".data"}, rd, exp);
        chk({tag, ".err"}, err, exp_err);
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input logic [1:0] pulse, input logic exp_err);
        logic [7:0] rd;
        logic       err;
        apb(tag, 1'b1, a, d, pulse, rd, err);
        chk({tag, ".err"}, err, exp_err);
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; ovf_set = 1'b0; udf_set = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        #1;
        chk("rst.pready", pready, 0);
        chk("rst.pslverr", pslverr, 0);
        chk("rst.prdata", prdata, 0);
        chk("rst.ctrl", {tdr_q, load_o, updw_o, en_o, cks_o, tdr_load_pulse}, 0);

        rd_chk("rst.tdr", 8'h00, 2'b00, 8'h00, 1'b0);
        rd_chk("rst.tcr", 8'h01, 2'b00, 8'h00, 1'b0);
        rd_chk("rst.tsr", 8'h02, 2'b00, 8'h00, 1'b0);

        // TCR write with all bits set: only B3 sticks, load pulse for one cycle
        wr_chk("tcr_ff", 8'h01, 8'hFF, 2'b00, 1'b0);
        #1;
        chk("tcr_ff.load_pulse", tdr_load_pulse, 1);
        chk("tcr_ff.en", en_o, 1);
        chk("tcr_ff.updw", updw_o, 1);
        chk("tcr_ff.cks", cks_o, 2'b11);
        chk("tcr_ff.load", load_o, 1);
        @(posedge pclk); #1;
        chk("tcr_ff.load_pulse_off", tdr_load_pulse, 0);
        rd_chk("tcr_rb", 8'h01, 2'b00, 8'hB3, 1'b0);
        chk("tcr_rb.load_kept", load_o, 1);

        // TDR write: visible on tdr_q in the cycle after the pready cycle
        wr_chk("tdr_5a", 8'h00, 8'h5A, 2'b00, 1'b0);
        #1;
        chk("tdr_5a.q", tdr_q, 8'h5A);
        chk("tdr_5a.no_load_pulse", tdr_load_pulse, 0);
        rd_chk("tdr_rb", 8'h00, 2'b00, 8'h5A, 1'b0);

        // TSR set / W1C behaviour
        @(posedge pclk); #1 udf_set = 1'b1;
        @(posedge pclk); #1 udf_set = 1'b0;
        rd_chk("tsr_udf", 8'h02, 2'b00, 8'h02, 1'b0);
        wr_chk("tsr_w1c", 8'h02, 8'h02, 2'b00, 1'b0);
        rd_chk("tsr_clr", 8'h02, 2'b00, 8'h00, 1'b0);
        wr_chk("tsr_w1c_set", 8'h02, 8'h02, 2'b10, 1'b0);
        rd_chk("tsr_setwins", 8'h02, 2'b00, 8'h02, 1'b0);
        rd_chk("tsr_rd_ovf", 8'h02, 2'b01, 8'h02, 1'b0);
        rd_chk("tsr_next", 8'h02, 2'b00, 8'h03, 1'b0);
        wr_chk("tsr_w1c_ff", 8'h02, 8'hFF, 2'b00, 1'b0);
        rd_chk("tsr_all_clr", 8'h02, 2'b00, 8'h00, 1'b0);

        // Unmapped addresses
        rd_chk("bad_rd07", 8'h07, 2'b00, 8'h00, 1'b1);
        rd_chk("bad_rd03", 8'h03, 2'b00, 8'h00, 1'b1);
        wr_chk("bad_wr07", 8'h07, 8'hFF, 2'b00, 1'b1);
        #1;
        chk("bad_wr07.tdr_q", tdr_q, 8'h5A);
        chk("bad_wr07.load_pulse", tdr_load_pulse, 0);
        rd_chk("bad_wr07.tcr", 8'h01, 2'b00, 8'hB3, 1'b0);
        rd_chk("bad_wr07.tsr", 8'h02, 2'b00, 8'h00, 1'b0);

        // Non-zero state, then reset in the middle of a TDR write
        wr_chk("tdr_80", 8'h00, 8'h80, 2'b00, 1'b0);
        wr_chk("tcr_10", 8'h01, 8'h10, 2'b00, 1'b0);
        #1;
        chk("tcr_10.load_pulse", tdr_load_pulse, 0);
        chk("tcr_10.ctrl", {tdr_q, load_o, updw_o, en_o, cks_o}, {8'h80, 1'b0, 1'b0, 1'b1, 2'b00});

        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h33;
        @(posedge pclk); #1 penable = 1'b1;
        #1 chk("rst_mid.c1", pready, 0);
        @(posedge pclk); #2;
        chk("rst_mid.c2", pready, 0);
        @(posedge pclk); #1 preset = 1'b1; ovf_set = 1'b1; udf_set = 1'b1;
        #1 chk("rst_mid.c3", pready, 0);
        @(posedge pclk); #1 preset = 1'b0; ovf_set = 1'b0; udf_set = 1'b0;
        #1 chk("rst_mid.c4", pready, 0);
        psel = 1'b0; penable = 1'b0;
        chk("rst_mid.ctrl", {tdr_q, load_o, updw_o, en_o, cks_o, tdr_load_pulse}, 0);
        rd_chk("rst_mid.tdr", 8'h00, 2'b00, 8'h00, 1'b0);
        rd_chk("rst_mid.tcr", 8'h01, 2'b00, 8'h00, 1'b0);
        rd_chk("rst_mid.tsr", 8'h02, 2'b00, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
